// File: rtl/common_pkg.sv
// Shared types and constants for the mini_core data-memory bridge.
package common_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } t_dmem_bridge_state;

  typedef struct packed {
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byte_en;
  } t_dmem_req;

  localparam logic [31:0] DMEM_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mini_core_dmem_req_fifo.sv
// Synchronous request FIFO for the dmem bridge; head is presented combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.

`ifndef MAFIA_DFF_RST
// NOTE: state registers update with <= so every flop samples pre-edge values.
`define MAFIA_DFF_RST(q, d, clk, rst) \
  always_ff @(posedge clk or negedge rst) \
    if (!rst) q <= '0; \
    else      q <= d;
`endif

`ifndef MAFIA_EN_DFF
`define MAFIA_EN_DFF(q, d, clk, en) \
  always_ff @(posedge clk) \
    if (en) q <= d;
`endif

module mini_core_dmem_req_fifo
  import common_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Rst,
  input  logic                     Push,
  input  t_dmem_req                PushData,
  input  logic                     Pop,
  output t_dmem_req                PopData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  t_dmem_req        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [CNT_W-1:0] countNext;
  logic             doPush, doPop;

  assign doPush    = Push && !Full;
  assign doPop     = Pop && !Empty;
  assign wrPtrNext = doPush ? wrPtr + PTR_W'(1) : wrPtr;
  assign rdPtrNext = doPop  ? rdPtr + PTR_W'(1) : rdPtr;

  always_comb begin
    // NOTE: default first so no path leaves countNext unassigned (no latch).
    countNext = Count;
    case ({doPush, doPop})
      2'b10:   countNext = Count + CNT_W'(1);
      2'b01:   countNext = Count - CNT_W'(1);
      default: countNext = Count;
    endcase
  end

  `MAFIA_DFF_RST(wrPtr, wrPtrNext, Clock, Rst)
  `MAFIA_DFF_RST(rdPtr, rdPtrNext, Clock, Rst)
  `MAFIA_DFF_RST(Count, countNext, Clock, Rst)

  // NOTE: storage is not reset; Count gates every read, so stale entries are never seen.
  `MAFIA_EN_DFF(mem[wrPtr], PushData, Clock, doPush)

  assign PopData = mem[rdPtr];
  assign Full    = (Count == CNT_W'(DEPTH));
  assign Empty   = (Count == '0);

endmodule

// File: rtl/mini_core_dmem_bridge.sv
// Q103H/Q104H data-memory bridge: posted stores, in-order blocking loads.
// Optional load watchdog enabled by defining MINI_CORE_DMEM_TIMEOUT_EN.
module mini_core_dmem_bridge
  import common_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        DMemRdEnQ103H,
  input  logic        DMemWrEnQ103H,
  input  logic [31:0] DMemAddressQ103H,
  input  logic [31:0] DMemWrDataQ103H,
  input  logic [3:0]  DMemByteEnQ103H,
  output logic        DMemReady,
  output logic        DMemRdRspValid,
  output logic [31:0] DMemRdRspQ104H,
  output logic        DMemRspErr,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic        MemReqWrEn,
  output logic [31:0] MemReqAddress,
  output logic [31:0] MemReqData,
  output logic [3:0]  MemReqByteEn,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData
);

  localparam int CNT_W = $clog2(REQ_FIFO_DEPTH) + 1;

  if (REQ_FIFO_DEPTH < 2 || (REQ_FIFO_DEPTH & (REQ_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("REQ_FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  t_dmem_bridge_state state, nextState;
  t_dmem_req          pushReq, headReq;
  logic [CNT_W-1:0]   count;
  logic               full, empty;
  logic               coreReq, push, loadAccept, pop, rspTake;
  logic               timeoutHit, stale, staleBlock;

  assign coreReq    = DMemRdEnQ103H || DMemWrEnQ103H;
  // A stale read still owed by memory blocks new loads only; stores keep flowing.
  assign staleBlock = stale && DMemRdEnQ103H && !DMemWrEnQ103H;
  assign DMemReady  = (count != CNT_W'(REQ_FIFO_DEPTH)) && (state == IDLE) && !staleBlock;
  assign push       = coreReq && DMemReady;
  assign loadAccept = push && !DMemWrEnQ103H;
  assign pop        = MemReqValid && MemReqReady;

  assign pushReq = '{wr_en:   DMemWrEnQ103H,
                     address: DMemAddressQ103H,
                     data:    DMemWrDataQ103H,
                     byte_en: DMemByteEnQ103H};

  mini_core_dmem_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
    .Clock    (Clock),
    .Rst      (Rst),
    .Push     (push),
    .PushData (pushReq),
    .Pop      (pop),
    .PopData  (headReq),
    .Full     (full),
    .Empty    (empty),
    .Count    (count)
  );

  assign MemReqValid   = !empty;
  assign MemReqWrEn    = headReq.wr_en;
  assign MemReqAddress = headReq.address;
  assign MemReqData    = headReq.data;
  assign MemReqByteEn  = headReq.byte_en;

  always_comb begin
    nextState = state;
    rspTake   = 1'b0;
    case (state)
      IDLE:     if (loadAccept) nextState = WAIT_RSP;
      WAIT_RSP: begin
        rspTake = MemRspValid;
        if (MemRspValid || timeoutHit) nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state          <= IDLE;
      DMemRdRspValid <= 1'b0;
      DMemRdRspQ104H <= '0;
    end else begin
      state          <= nextState;
      DMemRdRspValid <= rspTake || timeoutHit;
      if (rspTake)         DMemRdRspQ104H <= MemRspData;
      else if (timeoutHit) DMemRdRspQ104H <= DMEM_TIMEOUT_DATA;
    end
  end

`ifdef MINI_CORE_DMEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] watchdog;

  // A real response in the limit cycle wins over the timeout.
  assign timeoutHit = (state == WAIT_RSP) && !MemRspValid &&
                      (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      watchdog   <= '0;
      stale      <= 1'b0;
      DMemRspErr <= 1'b0;
    end else begin
      watchdog   <= (state == WAIT_RSP) ? watchdog + WD_W'(1) : '0;
      DMemRspErr <= timeoutHit;
      if (timeoutHit)                                   stale <= 1'b1;
      else if (stale && MemRspValid && state == IDLE)   stale <= 1'b0;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign stale      = 1'b0;
  assign DMemRspErr = 1'b0;
`endif

  always @(posedge Clock) begin
    if (Rst) begin
      assert (!(push && DMemRdEnQ103H && DMemWrEnQ103H))
        else $warning("dmem bridge: load and store enables both high, treated as store");
      assert (!(MemRspValid && state == IDLE && !stale))
        else $warning("dmem bridge: unsolicited memory response dropped");
      assert (!(push && full))
        else $warning("dmem bridge: push into full request fifo");
    end
  end

endmodule
